// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: data width, parity and stop bits fixed at elaboration.
// A one-entry holding register behind a valid/ready handshake keeps frames back-to-back.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_active,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_chk_clks
    $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_chk_pen
    $error("uart_tx_cfg: PARITY_EN must be 0 or 1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_podd
    $error("uart_tx_cfg: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [CW-1:0]        clk_count;
  logic [BW-1:0]        bit_index;
  logic                 stop_count;
  logic [DATA_BITS-1:0] shifter;
  logic [DATA_BITS-1:0] hold_reg;
  logic                 hold_full;

  logic          clk_last;
  logic          stop_end;
  logic          load;
  logic          transfer;
  logic [BW-1:0] next_index;
  logic          parity_bit;

  assign clk_last   = (clk_count == CLK_LAST);
  assign stop_end   = (state == STOP) && clk_last && (stop_count == STOP_LAST);
  assign load       = hold_full && ((state == IDLE) || stop_end);
  // The register emptied by a load may be refilled on the same edge.
  assign tx_ready   = !hold_full || load;
  assign transfer   = tx_valid && tx_ready;
  assign next_index = bit_index + 1'b1;
  assign parity_bit = (^shifter) ^ PARITY_ODD[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      clk_count  <= '0;
      bit_index  <= '0;
      stop_count <= 1'b0;
      shifter    <= '0;
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      tx_serial  <= 1'b1;
      tx_active  <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (transfer) begin
        hold_reg  <= tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (load) begin
            shifter   <= hold_reg;
            clk_count <= '0;
            state     <= START;
            tx_serial <= 1'b0;
            tx_active <= 1'b1;
          end
        end
        START: begin
          if (clk_last) begin
            clk_count <= '0;
            state     <= DATA;
            tx_serial <= shifter[0];
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        DATA: begin
          if (clk_last) begin
            clk_count <= '0;
            if (bit_index == BIT_LAST) begin
              bit_index <= '0;
              if (PARITY_EN != 0) begin
                state     <= PARITY;
                tx_serial <= parity_bit;
              end else begin
                state      <= STOP;
                stop_count <= 1'b0;
                tx_serial  <= 1'b1;
              end
            end else begin
              bit_index <= next_index;
              tx_serial <= shifter[next_index];
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        PARITY: begin
          if (clk_last) begin
            clk_count  <= '0;
            stop_count <= 1'b0;
            state      <= STOP;
            tx_serial  <= 1'b1;
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        STOP: begin
          if (clk_last) begin
            clk_count <= '0;
            if (stop_count == STOP_LAST) begin
              stop_count <= 1'b0;
              tx_done    <= 1'b1;
              if (hold_full) begin
                shifter   <= hold_reg;
                state     <= START;
                tx_serial <= 1'b0;
              end else begin
                state     <= IDLE;
                tx_serial <= 1'b1;
                tx_active <= 1'b0;
              end
            end else begin
              stop_count <= 1'b1;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five parameter sets side by side, random and directed words,
// frames rebuilt from the word by a bit-list model and checked cycle by cycle.
module tb_uart_tx_cfg;

  localparam int NCFG = 5;

  function automatic int cfg_c(input int g);
    return (g == 4) ? 3 : 4;
  endfunction
  function automatic int cfg_db(input int g);
    return (g == 3) ? 7 : ((g == 4) ? 9 : 8);
  endfunction
  function automatic int cfg_pe(input int g);
    return (g == 1 || g == 2 || g == 4) ? 1 : 0;
  endfunction
  function automatic int cfg_po(input int g);
    return (g == 2 || g == 4) ? 1 : 0;
  endfunction
  function automatic int cfg_sb(input int g);
    return (g == 1 || g == 2) ? 2 : 1;
  endfunction
  function automatic int cfg_len(input int g);
    return (1 + cfg_db(g) + cfg_pe(g) + cfg_sb(g)) * cfg_c(g);
  endfunction

  // Line level of frame bit i: start, data LSB first, optional parity, stop bits.
  function automatic logic frame_bit(input logic [8:0] w, input int i, input int db,
                                     input int pe, input int po);
    logic [8:0] m;
    m = 9'((1 << db) - 1);
    if (i == 0) return 1'b0;
    if (i <= db) return w[i-1];
    if (pe != 0 && i == db + 1) return 1'(($countones(w & m) + po) % 2);
    return 1'b1;
  endfunction

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tx_valid  [NCFG];
  logic [8:0] tx_data   [NCFG];
  logic       tx_ready  [NCFG];
  logic       tx_serial [NCFG];
  logic       tx_active [NCFG];
  logic       tx_done   [NCFG];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int frames_seen [NCFG];
  int done_seen   [NCFG];
  int last_start  [NCFG];
  int idle_glitch [NCFG];
  int issued      [NCFG];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int C  = cfg_c(g);
    localparam int DB = cfg_db(g);
    localparam int PE = cfg_pe(g);
    localparam int PO = cfg_po(g);
    localparam int SB = cfg_sb(g);
    localparam int NB = 1 + DB + PE + SB;

    logic [8:0] exp_q [$];

    uart_tx_cfg #(
      .CLKS_PER_BIT(C), .DATA_BITS(DB), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)
    ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .tx_valid(tx_valid[g]),
      .tx_data(tx_data[g][DB-1:0]),
      .tx_ready(tx_ready[g]),
      .tx_serial(tx_serial[g]),
      .tx_active(tx_active[g]),
      .tx_done(tx_done[g])
    );

    always @(posedge clk) begin
      if (reset_n && tx_valid[g] && tx_ready[g]) exp_q.push_back(tx_data[g]);
    end

    // Monitor: a low line outside a frame starts the next expected frame.
    initial begin : mon
      logic pend, ab, tok, eb, have;
      logic [8:0] w;
      logic [15:0] got_v, exp_v;
      pend = 1'b0;
      forever begin
        if (!pend) @(negedge clk);
        pend = 1'b0;
        if (!reset_n) begin
          exp_q.delete();
        end else if (tx_serial[g] !== 1'b0) begin
          if (tx_done[g] !== 1'b0 || tx_active[g] !== 1'b0) idle_glitch[g]++;
        end else begin
          frames_seen[g]++;
          last_start[g] = cyc;
          have = (exp_q.size() != 0);
          check_output($sformatf("frame_expected[%0d]", g), {31'd0, have}, 32'd1);
          w = have ? exp_q.pop_front() : 9'd0;
          ab = 1'b0; tok = 1'b1; got_v = '0; exp_v = '0;
          for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < C; c++) begin
              if (!ab) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (!reset_n) begin
                  ab = 1'b1;
                end else begin
                  eb = frame_bit(w, i, DB, PE, PO);
                  if (c == C / 2) begin
                    got_v[i] = tx_serial[g];
                    exp_v[i] = eb;
                  end
                  if (tx_serial[g] !== eb || tx_active[g] !== 1'b1) tok = 1'b0;
                  if (tx_done[g] !== 1'b0 && (i != 0 || c != 0)) tok = 1'b0;
                end
              end
            end
          end
          if (ab) begin
            exp_q.delete();
          end else begin
            if (have)
              check_output($sformatf("frame[%0d] word 0x%0h", g, w),
                           {15'd0, tok, got_v}, {15'd0, 1'b1, exp_v});
            @(negedge clk);
            if (!reset_n) begin
              exp_q.delete();
            end else begin
              check_output($sformatf("done_pulse[%0d]", g), {31'd0, tx_done[g]}, 32'd1);
              if (tx_done[g] === 1'b1) done_seen[g]++;
              if (tx_serial[g] === 1'b0) pend = 1'b1;
              else check_output($sformatf("active_end[%0d]", g), {31'd0, tx_active[g]}, 32'd0);
            end
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input int g, input logic [8:0] w, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    tx_valid[g] = 1'b1;
    tx_data[g]  = w;
    while (tx_ready[g] !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (tx_ready[g] !== 1'b1) begin
      check_output($sformatf("accept_timeout[%0d]", g), {31'd0, tx_ready[g]}, 32'd1);
      acc = -1;
    end else begin
      @(posedge clk);
      acc = cyc + 1;
      issued[g]++;
    end
  endtask

  task automatic drop_valid(input int g);
    @(negedge clk);
    tx_valid[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int target, input int budget);
    int t;
    t = 0;
    while (done_seen[g] < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_output($sformatf("drain[%0d]", g), done_seen[g], target);
  endtask

  initial begin : main
    int acc, a1, a2, a3, lows, fs, gap, s, t, len;
    int bad_idle [NCFG];
    logic [8:0] w;

    reset_n = 1'b0;
    for (int g = 0; g < NCFG; g++) begin
      tx_valid[g] = 1'b0;
      tx_data[g] = '0;
      frames_seen[g] = 0; done_seen[g] = 0; last_start[g] = 0;
      idle_glitch[g] = 0; issued[g] = 0; bad_idle[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NCFG; g++)
      check_output($sformatf("in_reset[%0d]", g),
                   {28'd0, tx_serial[g], tx_active[g], tx_ready[g], tx_done[g]}, 32'b1010);
    reset_n = 1'b1;

    repeat (20) begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++)
        if (tx_serial[g] !== 1'b1 || tx_active[g] !== 1'b0 ||
            tx_done[g] !== 1'b0 || tx_ready[g] !== 1'b1) bad_idle[g]++;
    end
    for (int g = 0; g < NCFG; g++)
      check_output($sformatf("reset_idle[%0d]", g), bad_idle[g], 0);

    // Single frames from idle: content by monitor, latency here.
    for (int g = 0; g < NCFG; g++) begin
      w = (g == 3) ? 9'h041 : 9'h0A5;
      apply_stimulus(g, w, acc);
      drop_valid(g);
      wait_done(g, issued[g], 4 * cfg_len(g));
      check_output($sformatf("latency[%0d]", g), last_start[g], acc + 1);
    end

    // Back-to-back with valid held high.
    for (int g = 0; g < 3; g += 2) begin
      len = cfg_len(g);
      apply_stimulus(g, 9'h055, a1);
      apply_stimulus(g, 9'h00F, a2);
      apply_stimulus(g, 9'h0F0, a3);
      drop_valid(g);
      check_output($sformatf("b2b_second_accept[%0d]", g), a2, a1 + 1);
      check_output($sformatf("b2b_third_accept[%0d]", g), a3, a1 + 1 + len);
      wait_done(g, issued[g], 5 * len);
      check_output($sformatf("b2b_contiguous[%0d]", g), last_start[g], a1 + 1 + 2 * len);
    end

    for (int g = 0; g < NCFG; g++) begin
      for (int n = 0; n < 8; n++) begin
        w = 9'($urandom_range(0, 511));
        apply_stimulus(g, w, acc);
        gap = $urandom_range(0, 3);
        if (gap > 0) begin
          drop_valid(g);
          repeat (gap - 1) @(negedge clk);
        end
      end
      drop_valid(g);
      wait_done(g, issued[g], 12 * cfg_len(g));
    end

    // Reset in data bit 3 with a second word pending.
    apply_stimulus(0, 9'h0F7, a1);
    apply_stimulus(0, 9'h0AA, a2);
    drop_valid(0);
    s = a1 + 1;
    t = 0;
    while (cyc < s + 17 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_output("pre_reset_line", {31'd0, tx_serial[0]},
                 {31'd0, frame_bit(9'h0F7, 4, 8, 0, 0)});
    #2 reset_n = 1'b0;
    #1 check_output("async_reset",
                    {28'd0, tx_serial[0], tx_active[0], tx_ready[0], tx_done[0]}, 32'b1010);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    fs = frames_seen[0];
    lows = 0;
    repeat (3 * cfg_len(0)) begin
      @(negedge clk);
      if (tx_serial[0] !== 1'b1) lows++;
    end
    check_output("discarded_word_line", lows, 0);
    check_output("discarded_word_frames", frames_seen[0], fs);
    check_output("post_reset_status", {30'd0, tx_active[0], tx_ready[0]}, 32'b01);

    for (int g = 0; g < NCFG; g++)
      check_output($sformatf("idle_glitch[%0d]", g), idle_glitch[g], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
